// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl: keypad-side controller for the combination lock.
//
// It collects up to four BCD digits from single-cycle key events and compares
// them with the stored password when the user confirms. A match drives
// `unlocked` for a timed window. Repeated misses raise `alarm` for a timed
// lockout. The segment digits and the wrong-attempt count feed the
// seven-segment display driver directly.
//
// Optional feature: define LOCK_PWD_CHANGE_EN to allow the password to be
// changed while the lock is open (key 12 enters SET). Without the macro,
// key 12 is ignored and the password is the constant PASSWORD.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, 10 clear, 11 confirm, 12 set-password, 13-15 ignored
//   seg_1..seg_4 entered digits in BCD, 4'hF = blank (seg_1 = first digit)
//   count_wrong  wrong attempts since last success / lockout end (0..9)
//   unlocked     high while the lock is open
//   alarm        high during lockout
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ENTRY   | collecting digits; clear and confirm accepted
// ST_CHECK   | single cycle: compare the entry with the password
// ST_OPEN    | unlocked, unlock timer counting down
// ST_LOCKOUT | alarm raised, lockout timer counting down, keys ignored
// ST_SET     | (feature) unlocked, timer frozen, collecting a new password

module lock_entry_ctrl #(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int          MAX_WRONG      = 3,
    parameter int          UNLOCK_CYCLES  = 250_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] seg_1,
    output logic [3:0] seg_2,
    output logic [3:0] seg_3,
    output logic [3:0] seg_4,
    output logic [3:0] count_wrong,
    output logic       unlocked,
    output logic       alarm
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [15:0]   ALL_BLANK    = 16'hFFFF;
    localparam logic [3:0]    WRONG_LIMIT  = 4'(MAX_WRONG);

`ifdef LOCK_PWD_CHANGE_EN
    typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKOUT, ST_SET} state_t;
`else
    typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKOUT} state_t;
`endif

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            unl_q, unl_d;
    logic            alm_q, alm_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     pwd;

    logic            digit_key, clear_key, confirm_key, entry_full, timer_done;
    logic [3:0]      cnt_inc;

    assign digit_key   = key_valid && (key_code <= 4'd9);
    assign clear_key   = key_valid && (key_code == 4'd10);
    assign confirm_key = key_valid && (key_code == 4'd11);
    assign entry_full  = (ptr_q == 3'd4);
    assign timer_done  = (timer_q == '0);
    assign cnt_inc     = (cnt_q >= 4'd9) ? 4'd9 : cnt_q + 4'd1;

`ifdef LOCK_PWD_CHANGE_EN
    logic        set_key;
    logic [15:0] pwd_q, pwd_d;
    assign set_key = key_valid && (key_code == 4'd12);
    assign pwd     = pwd_q;
`else
    assign pwd     = PASSWORD;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ENTRY;
            ptr_q    <= 3'd0;
            digits_q <= ALL_BLANK;
            cnt_q    <= 4'd0;
            unl_q    <= 1'b0;
            alm_q    <= 1'b0;
            timer_q  <= '0;
`ifdef LOCK_PWD_CHANGE_EN
            pwd_q    <= PASSWORD;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            unl_q    <= unl_d;
            alm_q    <= alm_d;
            timer_q  <= timer_d;
`ifdef LOCK_PWD_CHANGE_EN
            pwd_q    <= pwd_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        unl_d    = unl_q;
        alm_d    = alm_q;
        timer_d  = timer_q;
`ifdef LOCK_PWD_CHANGE_EN
        pwd_d    = pwd_q;
`endif

        case (state_q)
`ifdef LOCK_PWD_CHANGE_EN
            ST_ENTRY, ST_SET: begin
`else
            ST_ENTRY: begin
`endif
                if (digit_key && !entry_full) begin
                    case (ptr_q)
                        3'd0:    digits_d[15:12] = key_code;
                        3'd1:    digits_d[11:8]  = key_code;
                        3'd2:    digits_d[7:4]   = key_code;
                        3'd3:    digits_d[3:0]   = key_code;
                        default: ;
                    endcase
                    ptr_d = ptr_q + 3'd1;
                end else if (clear_key) begin
                    digits_d = ALL_BLANK;
                    ptr_d    = 3'd0;
                end else if (confirm_key && entry_full) begin
`ifdef LOCK_PWD_CHANGE_EN
                    if (state_q == ST_SET) begin
                        pwd_d    = digits_q;
                        digits_d = ALL_BLANK;
                        ptr_d    = 3'd0;
                        unl_d    = 1'b0;
                        state_d  = ST_ENTRY;
                    end else begin
                        state_d  = ST_CHECK;
                    end
`else
                    state_d = ST_CHECK;
`endif
                end
            end

            ST_CHECK: begin
                digits_d = ALL_BLANK;
                ptr_d    = 3'd0;
                if (digits_q == pwd) begin
                    state_d = ST_OPEN;
                    unl_d   = 1'b1;
                    cnt_d   = 4'd0;
                    timer_d = UNLOCK_LOAD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= WRONG_LIMIT) begin
                        state_d = ST_LOCKOUT;
                        alm_d   = 1'b1;
                        timer_d = LOCKOUT_LOAD;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end

            ST_OPEN: begin
                // Expiry wins over any key arriving on the same cycle.
                if (timer_done || confirm_key) begin
                    state_d = ST_ENTRY;
                    unl_d   = 1'b0;
`ifdef LOCK_PWD_CHANGE_EN
                end else if (set_key) begin
                    state_d  = ST_SET;
                    digits_d = ALL_BLANK;
                    ptr_d    = 3'd0;
`endif
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d = ST_ENTRY;
                    alm_d   = 1'b0;
                    cnt_d   = 4'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: state_d = ST_ENTRY;
        endcase
    end

    assign seg_1       = digits_q[15:12];
    assign seg_2       = digits_q[11:8];
    assign seg_3       = digits_q[7:4];
    assign seg_4       = digits_q[3:0];
    assign count_wrong = cnt_q;
    assign unlocked    = unl_q;
    assign alarm       = alm_q;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl. Expected values are queued when a step
// is driven and popped when the outputs are sampled on the falling edge.
module tb_lock_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] seg_1, seg_2, seg_3, seg_4, count_wrong;
    logic       unlocked, alarm;

    lock_entry_ctrl #(
        .PASSWORD(16'h1234),
        .MAX_WRONG(3),
        .UNLOCK_CYCLES(10),
        .LOCKOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .seg_1(seg_1),
        .seg_2(seg_2),
        .seg_3(seg_3),
        .seg_4(seg_4),
        .count_wrong(count_wrong),
        .unlocked(unlocked),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=%0h required=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_outs(input string tag, input logic [15:0] segs,
                               input logic [3:0] cnt, input logic unl, input logic alm);
        push({tag, "_seg"}, {16'h0, segs});
        push({tag, "_cnt"}, {28'h0, cnt});
        push({tag, "_unl"}, {31'h0, unl});
        push({tag, "_alm"}, {31'h0, alm});
    endtask

    task automatic observe_outs();
        observe({16'h0, seg_1, seg_2, seg_3, seg_4});
        observe({28'h0, count_wrong});
        observe({31'h0, unlocked});
        observe({31'h0, alarm});
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic enter4(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    // Counts falling edges while unlocked stays high, bounded.
    task automatic unl_width(output int n);
        n = 0;
        while (unlocked === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset values
        repeat (2) @(negedge clk);
        expect_outs("reset", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        rst_n = 1'b1;

        // correct code, timed unlock window
        enter4(16'h1234);
        expect_outs("digits", 16'h1234, 4'd0, 1'b0, 1'b0);
        observe_outs();
        press(4'd11);
        expect_outs("check_cycle", 16'h1234, 4'd0, 1'b0, 1'b0);
        observe_outs();
        @(negedge clk);
        expect_outs("open", 16'hFFFF, 4'd0, 1'b1, 1'b0);
        observe_outs();
        push("unl_width", 32'd10);
        unl_width(n);
        observe(n);
        expect_outs("open_end", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();

        // three wrong attempts lead to lockout
        for (int i = 1; i <= 3; i++) begin
            enter4(16'h1235);
            press(4'd11);
            @(negedge clk);
            expect_outs("wrong", 16'hFFFF, 4'(i), 1'b0, (i == 3));
            observe_outs();
        end
        push("alarm_width", 32'd20);
        n = 0;
        while (alarm === 1'b1 && n < 100) begin
            key_valid = 1'b1;
            key_code  = 4'(n % 12);
            @(negedge clk);
            n++;
        end
        key_valid = 1'b0;
        key_code  = 4'd0;
        observe(n);
        expect_outs("lockout_end", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();

        // short confirm, clear, fifth digit
        press(4'd7);
        press(4'd8);
        press(4'd11);
        @(negedge clk);
        expect_outs("short_confirm", 16'h78FF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        press(4'd10);
        expect_outs("clear", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        enter4(16'h1234);
        press(4'd9);
        expect_outs("fifth_digit", 16'h1234, 4'd0, 1'b0, 1'b0);
        observe_outs();
        press(4'd10);
        press(4'd12);
        press(4'd14);
        press(4'd5);
        expect_outs("codes_12_14", 16'h5FFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        press(4'd10);

        // one miss then success clears the count; confirm closes the lock
        enter4(16'h1235);
        press(4'd11);
        @(negedge clk);
        expect_outs("one_wrong", 16'hFFFF, 4'd1, 1'b0, 1'b0);
        observe_outs();
        enter4(16'h1234);
        press(4'd11);
        @(negedge clk);
        expect_outs("recover", 16'hFFFF, 4'd0, 1'b1, 1'b0);
        observe_outs();
        press(4'd11);
        expect_outs("confirm_close", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();

        // async reset in the middle of entry
        press(4'd1);
        press(4'd2);
        expect_outs("mid_entry", 16'h12FF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        #1 rst_n = 1'b0;
        #1;
        expect_outs("rst_entry", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // async reset in the middle of lockout
        for (int i = 0; i < 3; i++) begin
            enter4(16'h9999);
            press(4'd11);
        end
        repeat (5) @(negedge clk);
        expect_outs("mid_lockout", 16'hFFFF, 4'd3, 1'b0, 1'b1);
        observe_outs();
        #1 rst_n = 1'b0;
        #1;
        expect_outs("rst_lockout", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        @(negedge clk);
        rst_n = 1'b1;
        enter4(16'h1234);
        press(4'd11);
        @(negedge clk);
        expect_outs("after_reset_open", 16'hFFFF, 4'd0, 1'b1, 1'b0);
        observe_outs();
        unl_width(n);

`ifdef LOCK_PWD_CHANGE_EN
        // password change, timer frozen while in SET
        enter4(16'h1234);
        press(4'd11);
        @(negedge clk);
        press(4'd12);
        repeat (15) @(negedge clk);
        expect_outs("set_frozen", 16'hFFFF, 4'd0, 1'b1, 1'b0);
        observe_outs();
        enter4(16'h9876);
        expect_outs("set_digits", 16'h9876, 4'd0, 1'b1, 1'b0);
        observe_outs();
        press(4'd11);
        expect_outs("set_done", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        observe_outs();
        enter4(16'h1234);
        press(4'd11);
        @(negedge clk);
        expect_outs("old_pwd", 16'hFFFF, 4'd1, 1'b0, 1'b0);
        observe_outs();
        enter4(16'h9876);
        press(4'd11);
        @(negedge clk);
        expect_outs("new_pwd", 16'hFFFF, 4'd0, 1'b1, 1'b0);
        observe_outs();
        unl_width(n);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enter4(16'h9876);
        press(4'd11);
        @(negedge clk);
        expect_outs("pwd_restored", 16'hFFFF, 4'd1, 1'b0, 1'b0);
        observe_outs();
`else
        // key 12 in OPEN is ignored: the window still expires on time
        enter4(16'h1234);
        press(4'd11);
        @(negedge clk);
        press(4'd12);
        push("unl_width_key12", 32'd8);
        unl_width(n);
        observe(n);
`endif

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
